card_deck: RTL and testbench

Card source for the Black Jack datapath, sitting directly upstream of `BlackJackFSM` and driving its `CARD` input. It holds a 52-card deck in a register file, fills it after reset and shuffles it with an in-place Fisher-Yates pass driven by an LFSR. On request it deals one Black Jack card value per cycle: A=1, 2–10 face value, J/Q/K=10. The player and dealer hit logic issues `REQ`.

---
 rtl/blackjack_pkg.sv | 36 +++
 rtl/lfsr16.sv | 41 ++++
 rtl/card_deck.sv | 167 ++++++++++++++++
 tb/tb_card_deck.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared types, constants and helpers for the Black Jack card source.
//   deck_state_t : deck controller states (FILL, SHUF, READY)
//   DECK_SIZE    : cards per deck
//   RANKS        : ranks per suit
//   LFSR_TAPS    : Fibonacci tap mask for x^16+x^14+x^13+x^11
//   card_value() : rank index (0..12) to Black Jack value (1..10)
//   mask()       : smallest all-ones value >= i, bounds the swap candidate
package blackjack_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      SHUF  = 2'd1,
      READY = 2'd2
   } deck_state_t;

   localparam int DECK_SIZE = 52;
   localparam int RANKS     = 13;

   // Bits 15,13,12,10 feed the XOR for x^16+x^14+x^13+x^11.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Ace is rank 0 -> 1; ranks 9..12 (10,J,Q,K) all score 10.
   function automatic logic [3:0] card_value(input logic [3:0] rank);
      return (rank >= 4'd9) ? 4'd10 : rank + 4'd1;
   endfunction

   // Smear the highest set bit downward to get the enclosing all-ones mask.
   function automatic logic [5:0] mask(input logic [5:0] i);
      logic [5:0] m;
      m = i | (i >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      return m;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used as the shuffle random source.
//   CLK   : clock, rising edge
//   RESET : synchronous active-high, loads SEED
//   LOAD  : synchronous reload of SEED
//   SEED  : load value, must be nonzero
//   EN    : advance one step
//   Q     : current LFSR state
module lfsr16
   import blackjack_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        LOAD,
   input  logic [15:0] SEED,
   input  logic        EN,
   output logic [15:0] Q
);

   logic [15:0] q_q;
   logic [15:0] q_d;

   always_comb begin
      q_d = q_q;
      if (LOAD) begin
         q_d = SEED;
      end else if (EN) begin
         q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         q_q <= SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

endmodule

// File: rtl/card_deck.sv
// 52-card deck for the Black Jack datapath: fills in rank order, optionally
// shuffles in place (Fisher-Yates driven by lfsr16), then deals one card
// value per request.
//   CLK        : clock, rising edge
//   RESET      : synchronous active-high
//   REQ        : deal request, sampled every cycle
//   SHUFFLE    : restart fill (and shuffle); wins over REQ
//   CARD       : last dealt value 1..10, held between deals
//   CARD_VALID : one-cycle pulse when CARD updates
//   REMAIN     : cards left to deal
//   EMPTY      : READY with nothing left
//   BUSY       : fill or shuffle in progress
// Handshake: a deal is accepted on a rising edge where REQ=1, the deck is
// READY with REMAIN>0 and SHUFFLE=0; the card appears with CARD_VALID one
// cycle later. Requests that are not accepted are dropped, never queued.
module card_deck
   import blackjack_pkg::*;
#(
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter logic        SHUFFLE_EN = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ,
   input  logic       SHUFFLE,
   output logic [3:0] CARD,
   output logic       CARD_VALID,
   output logic [5:0] REMAIN,
   output logic       EMPTY,
   output logic       BUSY
);

   deck_state_t state_q, state_d;
   logic [5:0]  k_q, k_d;
   logic [3:0]  rank_q, rank_d;
   logic [1:0]  suit_q, suit_d;
   logic [5:0]  i_q, i_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [5:0]  remain_q, remain_d;
   logic [3:0]  card_q, card_d;
   logic        valid_q, valid_d;
   logic [3:0]  deck_q [DECK_SIZE];
   logic [3:0]  deck_d [DECK_SIZE];

   logic [15:0] lfsr_q;
   logic [9:0]  lfsr_unused;
   logic [5:0]  j;

   lfsr16 u_lfsr (
      .CLK   (CLK),
      .RESET (RESET),
      .LOAD  (1'b0),
      .SEED  (SEED),
      .EN    (state_q == SHUF),
      .Q     (lfsr_q)
   );

   assign lfsr_unused = lfsr_q[15:6];

   // Candidate swap partner; rejected when it lands above i.
   assign j = lfsr_q[5:0] & mask(i_q);

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      rank_d   = rank_q;
      suit_d   = suit_q;
      i_d      = i_q;
      ptr_d    = ptr_q;
      remain_d = remain_q;
      card_d   = card_q;
      valid_d  = 1'b0;
      deck_d   = deck_q;

      if (SHUFFLE) begin
         state_d  = FILL;
         k_d      = 6'd0;
         rank_d   = 4'd0;
         suit_d   = 2'd0;
         remain_d = 6'd0;
      end else begin
         case (state_q)
            FILL: begin
               deck_d[k_q] = card_value(rank_q);
               k_d = k_q + 6'd1;
               if (rank_q == 4'(RANKS - 1)) begin
                  rank_d = 4'd0;
                  suit_d = suit_q + 2'd1;
               end else begin
                  rank_d = rank_q + 4'd1;
               end
               // Last write: king of the fourth suit.
               if (suit_q == 2'd3 && rank_q == 4'(RANKS - 1)) begin
                  i_d = 6'(DECK_SIZE - 1);
                  if (SHUFFLE_EN) begin
                     state_d = SHUF;
                  end else begin
                     state_d  = READY;
                     ptr_d    = 6'd0;
                     remain_d = 6'(DECK_SIZE);
                  end
               end
            end
            SHUF: begin
               if (j <= i_q) begin
                  // j == i is a legal no-op swap.
                  deck_d[i_q] = deck_q[j];
                  deck_d[j]   = deck_q[i_q];
                  i_d = i_q - 6'd1;
                  if (i_q == 6'd1) begin
                     state_d  = READY;
                     ptr_d    = 6'd0;
                     remain_d = 6'(DECK_SIZE);
                  end
               end
            end
            READY: begin
               if (REQ && remain_q != 6'd0) begin
                  card_d   = deck_q[ptr_q];
                  valid_d  = 1'b1;
                  ptr_d    = ptr_q + 6'd1;
                  remain_d = remain_q - 6'd1;
               end
            end
            default: begin
               state_d = FILL;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= FILL;
         k_q      <= 6'd0;
         rank_q   <= 4'd0;
         suit_q   <= 2'd0;
         i_q      <= 6'd0;
         ptr_q    <= 6'd0;
         remain_q <= 6'd0;
         card_q   <= 4'd0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         rank_q   <= rank_d;
         suit_q   <= suit_d;
         i_q      <= i_d;
         ptr_q    <= ptr_d;
         remain_q <= remain_d;
         card_q   <= card_d;
         valid_q  <= valid_d;
      end
   end

   // Deck contents are rewritten by FILL, so they need no reset.
   always_ff @(posedge CLK) begin
      deck_q <= deck_d;
   end

   assign CARD       = card_q;
   assign CARD_VALID = valid_q;
   assign REMAIN     = remain_q;
   assign EMPTY      = (state_q == READY) && (remain_q == 6'd0);
   assign BUSY       = (state_q != READY);

endmodule

// File: tb/tb_card_deck.sv
module tb_card_deck;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, req, shuf;
   logic [3:0] card_o, card_s;
   logic       valid_o, valid_s, empty_o, empty_s, busy_o, busy_s;
   logic [5:0] remain_o, remain_s;

   // Ordered deck (no shuffle) and shuffled deck share all inputs.
   card_deck #(.SEED(16'hACE1), .SHUFFLE_EN(1'b0)) dut_o (
      .CLK(clk), .RESET(rst), .REQ(req), .SHUFFLE(shuf),
      .CARD(card_o), .CARD_VALID(valid_o), .REMAIN(remain_o),
      .EMPTY(empty_o), .BUSY(busy_o)
   );

   card_deck #(.SEED(16'hACE1), .SHUFFLE_EN(1'b1)) dut_s (
      .CLK(clk), .RESET(rst), .REQ(req), .SHUFFLE(shuf),
      .CARD(card_s), .CARD_VALID(valid_s), .REMAIN(remain_s),
      .EMPTY(empty_s), .BUSY(busy_s)
   );

   logic       sel;      // 0: watch dut_o, 1: watch dut_s
   logic       capture;  // collect dealt cards instead of comparing
   logic [3:0] card_m;
   logic       valid_m, busy_m, empty_m;
   logic [5:0] remain_m;

   assign card_m   = sel ? card_s   : card_o;
   assign valid_m  = sel ? valid_s  : valid_o;
   assign busy_m   = sel ? busy_s   : busy_o;
   assign empty_m  = sel ? empty_s  : empty_o;
   assign remain_m = sel ? remain_s : remain_o;

   logic [3:0] exp_q[$];
   logic [3:0] cap_q[$];
   logic [3:0] run1 [52];
   logic [3:0] fill_tbl [13];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops one expected card per CARD_VALID pulse.
   always @(negedge clk) begin
      if (valid_m) begin
         if (busy_m) begin
            n_vec++;
            n_err++;
            $display("FAIL valid_while_busy: CARD_VALID=1 BUSY=1 (t=%0t)", $time);
         end
         if (capture) begin
            cap_q.push_back(card_m);
         end else if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_deal: got card %0d expected no pulse (t=%0t)",
                     card_m, $time);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (card_m !== e) begin
               n_err++;
               $display("FAIL deal_card: got %0d expected %0d (t=%0t)", card_m, e, $time);
            end
         end
      end
   end

   task automatic deal(input int n);
      req = 1'b1;
      repeat (n) @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready(input int limit, output int cyc);
      cyc = 0;
      @(negedge clk);
      while (busy_m && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      if (busy_m) begin
         n_vec++;
         n_err++;
         $display("FAIL ready_timeout: BUSY still 1 after %0d cycles", cyc);
      end
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int cnt;
      int bad;
      int sum;
      int diff;
      int hist [11];

      fill_tbl = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                   4'd8, 4'd9, 4'd10, 4'd10, 4'd10, 4'd10};
      rst = 1'b1; req = 1'b0; shuf = 1'b0; sel = 1'b0; capture = 1'b0;

      // Reset and fill, with REQ held during the first BUSY cycles.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      req = 1'b1;
      cnt = 0;
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (c == 5) req = 1'b0;
         if (!busy_o) break;
         cnt++;
         if (card_o !== 4'd0 || valid_o !== 1'b0 || remain_o !== 6'd0 || empty_o !== 1'b0)
            bad = 1;
      end
      req = 1'b0;
      check("fill_busy_cycles", cnt, 52);
      check("fill_outputs_idle", bad, 0);
      check("fill_remain", remain_o, 52);
      check("fill_empty", empty_o, 0);
      check("fill_card_held", card_o, 0);

      // Ordered deal of 14.
      for (int k = 0; k < 14; k++) exp_q.push_back(fill_tbl[k % 13]);
      deal(14);
      check("ordered_remain", remain_o, 38);
      check("ordered_empty", empty_o, 0);
      check("ordered_drained", exp_q.size(), 0);

      // Exhaustion.
      for (int k = 14; k < 52; k++) exp_q.push_back(fill_tbl[k % 13]);
      deal(38);
      check("exhaust_remain", remain_o, 0);
      check("exhaust_empty", empty_o, 1);
      check("exhaust_drained", exp_q.size(), 0);
      deal(1);
      check("extra_req_card", card_o, 10);
      check("extra_req_empty", empty_o, 1);

      // Reshuffle, then SHUFFLE and REQ together in READY.
      shuf = 1'b1;
      @(posedge clk);
      #1 shuf = 1'b0;
      check("shuffle_busy", busy_o, 1);
      check("shuffle_empty_clear", empty_o, 0);
      wait_ready(200, cnt);
      check("refill_remain", remain_o, 52);
      shuf = 1'b1;
      req  = 1'b1;
      @(posedge clk);
      #1 shuf = 1'b0;
      req = 1'b0;
      @(negedge clk);
      check("conflict_busy", busy_o, 1);
      check("conflict_remain", remain_o, 0);
      check("conflict_card_held", card_o, 10);

      // Shuffled deck integrity.
      sel = 1'b1;
      pulse_reset();
      wait_ready(2000, cnt);
      check("shuf_remain", remain_m, 52);
      capture = 1'b1;
      deal(52);
      capture = 1'b0;
      check("shuf_count", cap_q.size(), 52);
      sum = 0;
      diff = 0;
      for (int v = 0; v < 11; v++) hist[v] = 0;
      for (int k = 0; k < 52 && k < cap_q.size(); k++) begin
         run1[k] = cap_q[k];
         sum += int'(cap_q[k]);
         if (cap_q[k] <= 4'd10) hist[cap_q[k]]++;
         if (cap_q[k] != fill_tbl[k % 13]) diff++;
      end
      check("shuf_sum", sum, 340);
      for (int v = 1; v <= 10; v++) check($sformatf("shuf_hist_%0d", v), hist[v], (v == 10) ? 16 : 4);
      check("shuf_order_differs", int'(diff != 0), 1);
      check("shuf_empty", empty_m, 1);

      // Same seed after a clean reset repeats the sequence.
      pulse_reset();
      wait_ready(2000, cnt);
      for (int k = 0; k < 52; k++) exp_q.push_back(run1[k]);
      deal(52);
      check("repeat_drained", exp_q.size(), 0);

      // Reset in the middle of the shuffle pass.
      pulse_reset();
      repeat (70) @(posedge clk);
      #1;
      check("midshuf_busy", busy_s, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      wait_ready(2000, cnt);
      for (int k = 0; k < 52; k++) exp_q.push_back(run1[k]);
      deal(52);
      check("midshuf_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
